// File: rtl/systolic_array_nxn.sv
// Output-stationary N x N systolic matrix multiplier: streams columns of A and
// rows of B, accumulates C = A x B in place, then returns C one row at a time.
module systolic_array_nxn #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W+8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                signed_mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [N*DATA_W-1:0] in_a,
    input  logic [N*DATA_W-1:0] in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic [N*ACC_W-1:0]  out_row,
    output logic                busy,
    output logic                done,
    output logic [15:0]         beat_count
);
    localparam int ROW_W = $clog2(N);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUTPUT} state_t;

    // Both operands are widened to ACC_W first, so the low ACC_W product bits
    // equal the true product modulo 2^ACC_W for either signedness.
    function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic sm);
        logic signed [ACC_W-1:0] ae;
        logic signed [ACC_W-1:0] be;
        ae = sm ? {{(ACC_W-DATA_W){a[DATA_W-1]}}, a} : {{(ACC_W-DATA_W){1'b0}}, a};
        be = sm ? {{(ACC_W-DATA_W){b[DATA_W-1]}}, b} : {{(ACC_W-DATA_W){1'b0}}, b};
        return ae * be;
    endfunction

    state_t             state_q, state_d;
    logic               sm_q, sm_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [N*ACC_W-1:0] out_row_q, out_row_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [15:0]        bc_q, bc_d;
    logic [5:0]         drain_q, drain_d;
    logic [ROW_W-1:0]   row_q, row_d;

    logic [DATA_W-1:0] a_sk_q [N][N];
    logic [DATA_W-1:0] a_sk_d [N][N];
    logic [DATA_W-1:0] b_sk_q [N][N];
    logic [DATA_W-1:0] b_sk_d [N][N];
    logic [DATA_W-1:0] a_pe_q [N][N];
    logic [DATA_W-1:0] a_pe_d [N][N];
    logic [DATA_W-1:0] b_pe_q [N][N];
    logic [DATA_W-1:0] b_pe_d [N][N];
    logic [ACC_W-1:0]  acc_q  [N][N];
    logic [ACC_W-1:0]  acc_d  [N][N];

    logic [DATA_W-1:0] a_lane [N];
    logic [DATA_W-1:0] b_lane [N];
    logic [DATA_W-1:0] a_in   [N][N];
    logic [DATA_W-1:0] b_in   [N][N];

    logic fire_in, fire_out;

    assign fire_in  = in_valid && in_ready_q;
    assign fire_out = out_valid_q && out_ready;

    // Lane i enters the array after i skew registers; lane 0 feeds straight in.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        if (gi == 0) begin : g_direct
            assign a_lane[gi] = fire_in ? in_a[gi*DATA_W +: DATA_W] : '0;
            assign b_lane[gi] = fire_in ? in_b[gi*DATA_W +: DATA_W] : '0;
        end else begin : g_skew
            assign a_lane[gi] = a_sk_q[gi][gi-1];
            assign b_lane[gi] = b_sk_q[gi][gi-1];
        end
        for (genvar gj = 0; gj < N; gj++) begin : g_pe
            if (gj == 0) begin : g_a_edge
                assign a_in[gi][gj] = a_lane[gi];
            end else begin : g_a_hop
                assign a_in[gi][gj] = a_pe_q[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_in[gi][gj] = b_lane[gj];
            end else begin : g_b_hop
                assign b_in[gi][gj] = b_pe_q[gi-1][gj];
            end
        end
    end

    always_comb begin
        logic             clear;
        logic             load_row;
        logic [ROW_W-1:0] sel;
        state_d     = state_q;
        sm_d        = sm_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_row_d   = out_row_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bc_d        = bc_q;
        drain_d     = drain_q;
        row_d       = row_q;
        clear       = 1'b0;
        load_row    = 1'b0;
        sel         = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    sm_d       = signed_mode;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    bc_d       = '0;
                    clear      = 1'b1;
                end
            end
            LOAD: begin
                if (fire_in) begin
                    if (bc_q != 16'hFFFF) bc_d = bc_q + 16'd1;
                    if (in_last) begin
                        state_d    = DRAIN;
                        in_ready_d = 1'b0;
                        drain_d    = '0;
                    end
                end
            end
            DRAIN: begin
                // The last pair reaches PE(N-1,N-1) 2N-2 edges after E_last.
                drain_d = drain_q + 6'd1;
                if (drain_q == 6'(2*N-1)) begin
                    state_d     = OUTPUT;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    row_d       = '0;
                    load_row    = 1'b1;
                    sel         = '0;
                end
            end
            OUTPUT: begin
                if (fire_out) begin
                    if (row_q == ROW_W'(N-1)) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_row_d   = '0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        row_d      = row_q + ROW_W'(1);
                        out_last_d = (row_q + ROW_W'(1)) == ROW_W'(N-1);
                        load_row   = 1'b1;
                        sel        = row_q + ROW_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_row) begin
            for (int j = 0; j < N; j++) out_row_d[j*ACC_W +: ACC_W] = acc_q[sel][j];
        end

        for (int i = 0; i < N; i++) begin
            a_sk_d[i][0] = clear ? '0 : (fire_in ? in_a[i*DATA_W +: DATA_W] : '0);
            b_sk_d[i][0] = clear ? '0 : (fire_in ? in_b[i*DATA_W +: DATA_W] : '0);
            for (int d = 1; d < N; d++) begin
                a_sk_d[i][d] = clear ? '0 : a_sk_q[i][d-1];
                b_sk_d[i][d] = clear ? '0 : b_sk_q[i][d-1];
            end
            for (int j = 0; j < N; j++) begin
                a_pe_d[i][j] = clear ? '0 : a_in[i][j];
                b_pe_d[i][j] = clear ? '0 : b_in[i][j];
                acc_d[i][j]  = clear ? '0 : acc_q[i][j] + mul_ext(a_in[i][j], b_in[i][j], sm_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sm_q        <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_row_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bc_q        <= '0;
            drain_q     <= '0;
            row_q       <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_sk_q[i][j] <= '0;
                    b_sk_q[i][j] <= '0;
                    a_pe_q[i][j] <= '0;
                    b_pe_q[i][j] <= '0;
                    acc_q[i][j]  <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            sm_q        <= sm_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_row_q   <= out_row_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bc_q        <= bc_d;
            drain_q     <= drain_d;
            row_q       <= row_d;
            a_sk_q      <= a_sk_d;
            b_sk_q      <= b_sk_d;
            a_pe_q      <= a_pe_d;
            b_pe_q      <= b_pe_d;
            acc_q       <= acc_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_row    = out_row_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign beat_count = bc_q;

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Scoreboard bench for systolic_array_nxn: the driver pushes reference rows of
// C = A x B, an independent monitor pops and compares on every row handshake.
module tb_systolic_array_nxn;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            signed_mode = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic            out_ready = 1'b0;
    logic [N*DW-1:0] in_a = '0;
    logic [N*DW-1:0] in_b = '0;
    logic            in_ready, out_valid, out_last, busy, done;
    logic [N*AW-1:0] out_row;
    logic [15:0]     beat_count;

    systolic_array_nxn #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_row(out_row), .busy(busy), .done(done),
        .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int              checks = 0;
    int              failures = 0;
    int              e_last = -100;
    bit              seen_valid = 0;
    bit              stalled = 0;
    logic [N*AW-1:0] held_row;
    logic            held_last;
    int              hs_cnt = 0;
    int              done_pulses = 0;
    int              jobs_done = 0;
    logic [N*AW-1:0] exp_rows [$];
    bit              exp_last [$];
    logic [DW-1:0]   ma [N][16];
    logic [DW-1:0]   mb [16][N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer dot products, truncated to the result width.
    task automatic push_expected(input int k_len, input bit sm);
        for (int r = 0; r < N; r++) begin
            logic [N*AW-1:0] row;
            row = '0;
            for (int j = 0; j < N; j++) begin
                longint s;
                s = 0;
                for (int k = 0; k < k_len; k++) begin
                    longint x, y;
                    x = sm ? longint'($signed(ma[r][k])) : longint'(ma[r][k]);
                    y = sm ? longint'($signed(mb[k][j])) : longint'(mb[k][j]);
                    s += x * y;
                end
                row[j*AW +: AW] = s[AW-1:0];
            end
            exp_rows.push_back(row);
            exp_last.push_back(r == N-1);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (done) done_pulses++;
            if (out_valid) begin
                if (!seen_valid) begin
                    seen_valid = 1;
                    chk("out_valid_latency", 64'(cyc - e_last), 64'(2*N));
                end
                if (stalled) begin
                    chk("stall_row_stable", out_row, held_row);
                    chk("stall_last_stable", 64'(out_last), 64'(held_last));
                end
                if (out_ready) begin
                    stalled = 0;
                    hs_cnt++;
                    if (exp_rows.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_row actual=%0h expected=none", out_row);
                    end else begin
                        logic [N*AW-1:0] er;
                        bit              el;
                        er = exp_rows.pop_front();
                        el = exp_last.pop_front();
                        chk("out_row", out_row, er);
                        chk("out_last", 64'(out_last), 64'(el));
                    end
                end else begin
                    stalled   = 1;
                    held_row  = out_row;
                    held_last = out_last;
                end
            end else begin
                stalled = 0;
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 0);
        chk({tag, "_out_valid"}, 64'(out_valid), 0);
        chk({tag, "_out_last"}, 64'(out_last), 0);
        chk({tag, "_out_row"}, out_row, 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_beat_count"}, 64'(beat_count), 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < N; j++) begin
                ma[j][i] = DW'($urandom);
                mb[i][j] = DW'($urandom);
            end
    endtask

    task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < N; j++) begin
                ma[j][i] = av;
                mb[i][j] = bv;
            end
    endtask

    task automatic fill_identity(input bit b_ramp);
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < N; j++) begin
                ma[j][k] = (j == k) ? DW'(1) : DW'(0);
                mb[k][j] = b_ramp ? DW'(4*k + j + 1) : ((j == k) ? DW'(1) : DW'(0));
            end
    endtask

    // Driver steps run at posedge+1, clear of the active edge.
    task automatic start_job(input bit sm);
        start       = 1'b1;
        signed_mode = sm;
        seen_valid  = 0;
        hs_cnt      = 0;
        @(posedge clk); #1;
        start       = 1'b0;
        signed_mode = 1'($urandom_range(0, 1));
        chk("busy_after_start", 64'(busy), 1);
        chk("in_ready_after_start", 64'(in_ready), 1);
    endtask

    task automatic send_beats(input int k_len, input bit gap, input bit use_last);
        int k, slot;
        bit acc;
        k    = 0;
        slot = 0;
        while (k < k_len && slot < 1000) begin
            if (gap && (slot % 2 == 1)) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_a     = N*DW'($urandom);
                in_b     = N*DW'($urandom);
            end else begin
                in_valid = 1'b1;
                in_last  = use_last && (k == k_len - 1);
                for (int i = 0; i < N; i++) begin
                    in_a[i*DW +: DW] = ma[i][k];
                    in_b[i*DW +: DW] = mb[k][i];
                end
            end
            acc = in_valid && in_ready;
            if (acc && in_last) e_last = cyc + 1;
            @(posedge clk); #1;
            slot++;
            if (acc) k++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (k < k_len) chk("beats_timeout", 64'(k), 64'(k_len));
    endtask

    task automatic run_job(input int k_len, input bit sm, input bit gap, input int rmode);
        bit got_done;
        int p;
        push_expected(k_len, sm);
        start_job(sm);
        send_beats(k_len, gap, 1'b1);
        chk("beat_count", 64'(beat_count), 64'(k_len));
        chk("in_ready_after_last", 64'(in_ready), 0);
        got_done = 0;
        p = 0;
        while (!got_done && p < 200) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (p % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1;
            p++;
            if (done) got_done = 1;
        end
        chk("done_seen", 64'(got_done), 1);
        chk("handshakes", 64'(hs_cnt), 64'(N));
        chk("busy_at_done", 64'(busy), 0);
        chk("queue_empty", 64'(exp_rows.size()), 0);
        if (got_done) jobs_done++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_reset("reset_init");
        @(posedge clk); #1;
        reset = 1'b1;

        fill_identity(1'b1);
        run_job(4, 1'b0, 1'b0, 0);
        fill_const(8'hFD, 8'd5);
        run_job(4, 1'b1, 1'b0, 0);
        run_job(4, 1'b0, 1'b0, 0);
        fill_random();
        run_job(8, 1'b0, 1'b1, 0);
        fill_random();
        run_job(5, 1'b1, 1'b0, 1);
        fill_const(8'hFF, 8'hFF);
        run_job(2, 1'b0, 1'b0, 0);
        fill_random();
        run_job(1, 1'b1, 1'b0, 2);
        fill_random();
        run_job(16, 1'b1, 1'b1, 2);

        // Abort mid-LOAD.
        fill_random();
        start_job(1'b0);
        send_beats(2, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check_reset("reset_mid_load");
        @(posedge clk); #1;
        reset = 1'b1;

        // Abort mid-OUTPUT, with the sink stalled.
        fill_random();
        out_ready = 1'b0;
        start_job(1'b1);
        send_beats(3, 1'b0, 1'b1);
        begin
            int w;
            w = 0;
            while (!out_valid && w < 100) begin
                @(posedge clk); #1;
                w++;
            end
            chk("abort_out_valid_seen", 64'(out_valid), 1);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_reset("reset_mid_output");
        @(posedge clk); #1;
        reset = 1'b1;

        fill_identity(1'b0);
        run_job(4, 1'($urandom_range(0, 1)), 1'b0, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("done_pulse_count", 64'(done_pulses), 64'(jobs_done));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_array_nxn.md
# systolic_array_nxn

Parametrised N×N output-stationary systolic matrix multiplier, the generalised successor of the fixed 4×4 array.
- Computes C = A×B for an N×K by K×N product, with K set at run time by the stream length.
- Handles operand skewing internally, supports signed and unsigned operands and uses ready/valid streaming on both sides.
- Sits between the UART command/data path (operand source, result sink) and the PE/Booth multiplier datapath.

## Interface
- N, default 4: array dimension (rows = columns = N), 2..16.
- DATA_W, default 8: operand width.
- ACC_W, default 2*DATA_W+8: accumulator / result element width.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; one clock domain only.
- start  input  1  pulse in IDLE: clears accumulators, latches signed_mode, enters LOAD.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat.
- in_last  input  1  marks final beat (k = K-1).
- in_a  input  N*DATA_W  column k of A; slice i = A[i][k].
- in_b  input  N*DATA_W  row k of B; slice j = B[k][j].
- out_valid  output  1  result row valid.
- out_ready  input  1  sink accepts the row.
- out_last  output  1  high with row N-1.
- out_row  output  N*ACC_W  row r of C; slice j = C[r][j].
- busy  output  1  state ≠ IDLE.
- done  output  1  one-cycle pulse after the final result handshake.
- beat_count  output  16  beats accepted in the current job.

## Operation
- Four states: IDLE, LOAD, DRAIN, OUTPUT.
- IDLE:
  - start=1 → LOAD; all N² accumulators, skew registers and beat_count are zeroed.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1.
  - A beat transfers when in_valid && in_ready; beat_count increments.
  - Row i of A is delayed i cycles and column j of B is delayed j cycles by internal skew registers.
  - PE(i,j) does acc += a·b, then forwards a right and b down, one register per hop.
  - The array advances every cycle. Cycles without a beat inject zeros, so gaps contribute nothing.
  - A beat with in_last → DRAIN; in_ready drops in the following cycle.
- Products are DATA_W×DATA_W → 2*DATA_W bits.
  - Operands are sign-extended when signed_mode=1 and zero-extended otherwise.
  - Products are extended to ACC_W and summed modulo 2^ACC_W (wrap, no saturation, no flag).
- DRAIN: zeros are injected until the last operand pair has reached PE(N-1,N-1), then → OUTPUT.
- OUTPUT:
  - Row counter r starts at 0; out_row = C[r][*], out_valid=1.
  - On out_valid && out_ready, r increments.
  - out_row and out_last hold stable while out_ready=0.
  - Handshake on row N-1 → IDLE with done=1 for exactly one cycle.
- beat_count saturates at 0xFFFF. Accumulation of beats beyond 65535 continues unaffected.
- signed_mode changes after start have no effect until the next start.
- Asserting reset in any state returns to IDLE immediately and discards the partial job.

## Timing
- Reset values:
  - in_ready=0, out_valid=0, out_last=0, out_row=0, busy=0, done=0, beat_count=0.
  - All accumulators and skew registers are 0.
- start sampled at edge E → busy=1 and in_ready=1 from E.
- Let E_last be the edge accepting the in_last beat. out_valid rises at edge E_last+2N (8 cycles for N=4) and is independent of gaps earlier in the stream.
- With out_ready held high, rows 0..N-1 appear on consecutive cycles.
- done is high for the one cycle after the row N-1 handshake. busy falls on the same edge.
- A new start is accepted in the cycle done is high, giving back-to-back jobs.
- Throughput: one beat per cycle in LOAD. A job occupies K + 2N + N cycles minimum.
- K=1 (in_last on the first beat) is legal and gives the outer product A[:,0]·B[0,:].
- If in_valid=1 outside LOAD, no transfer happens and the beat is not consumed.

## Test plan
- N=4, signed_mode=0, A = identity, B[k][j] = 4k+j+1, K=4, in_valid continuous:
  - out_row rows equal B (1..16).
  - out_valid first rises 8 edges after E_last; done pulses once.
- Signed, N=4, all A = -3 (0xFD), all B = 5, K=4:
  - every C element = -60 (ACC_W two's complement).
  - Repeat unsigned → 253·5·4 = 5060.
- K=8 with in_valid low on every other cycle:
  - result equals a reference model; beat_count=8.
  - out_valid still at E_last+8.
- out_ready toggled 1,0,0,1,… during OUTPUT:
  - each row held stable while stalled.
  - out_last only with row 3; exactly 4 handshakes.
- Overflow, DATA_W=8, ACC_W=16, unsigned, all operands 255, K=2:
  - each element = (2·65025) mod 65536 = 64514.
- reset low for one cycle mid-LOAD and again mid-OUTPUT:
  - all outputs return to reset values immediately.
  - a following start with identity × identity yields identity, with no residue from the aborted job.
